// File: rtl/tow_pkg.sv
// -----------------------------------------------------------------------------
// tow_pkg
// Shared definitions for the tug-of-war scorer:
//   - scorer_state_t : round FSM states (PLAY, HOLD, OVER)
//   - SEG_BLANK      : all segments off (active-low)
//   - SEG_DIGIT      : active-low gfedcba patterns for digits 0..9
//   - seg7_encode()  : value -> pattern, blank for values above 9
// -----------------------------------------------------------------------------
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } scorer_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    function automatic logic [6:0] seg7_encode(input logic [3:0] value);
        logic [6:0] seg;
        if (value > 4'd9) begin
            seg = SEG_BLANK;
        end else begin
            seg = SEG_DIGIT[value];
        end
        return seg;
    endfunction

endpackage

// File: rtl/tow_seg7_digit.sv
// -----------------------------------------------------------------------------
// tow_seg7_digit
// Combinational seven-segment decode of one score digit.
// Ports:
//   value [3:0] in  : digit to show (values above 9 show blank)
//   blank       in  : force all segments off
//   seg   [6:0] out : active-low gfedcba pattern (unregistered)
// -----------------------------------------------------------------------------
module tow_seg7_digit
    import tow_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank overrides the decoded digit.
    always_comb begin
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg7_encode(value);
        end
    end

endmodule

// File: rtl/tow_round_scorer.sv
// -----------------------------------------------------------------------------
// tow_round_scorer
// Match-level score keeper for the tug-of-war game. Detects round wins from
// the end lights plus press pulses, bumps the winner's score, holds the board
// for HOLD_CYCLES, then pulses round_reset to restart the playfield. The match
// ends (game_over, sticky until reset) when a score reaches WIN_LIMIT.
//
// Parameters:
//   WIN_LIMIT    : score that ends the match (1..9)
//   HOLD_CYCLES  : cycles the finished board is held (>= 2)
//   BLINK_CYCLES : half-period of the winner blink in OVER
// Ports:
//   clk         in  : system clock
//   reset       in  : synchronous active-high match clear
//   L, R        in  : one-cycle player press pulses
//   lmost,rmost in  : leftmost / rightmost playfield lights
//   round_reset out : one-cycle playfield restart pulse (registered)
//   game_over   out : high while the match is finished (registered)
//   hex_left    out : active-low 7-seg of the left score (registered)
//   hex_right   out : active-low 7-seg of the right score (registered)
// Build option:
//   SCORER_BLINK_EN : when defined, the winner's digit blinks in OVER.
// -----------------------------------------------------------------------------
module tow_round_scorer
    import tow_pkg::*;
#(
    parameter int WIN_LIMIT    = 7,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       lmost,
    input  logic       rmost,
    output logic       round_reset,
    output logic       game_over,
    output logic [6:0] hex_left,
    output logic [6:0] hex_right
);

    localparam int              HC_W      = $clog2(HOLD_CYCLES);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]      LIMIT     = 4'(WIN_LIMIT);

    scorer_state_t   state_q, state_d;
    logic [3:0]      score_l_q, score_l_d;
    logic [3:0]      score_r_q, score_r_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            round_reset_q, round_reset_d;
    logic            game_over_q, game_over_d;
    logic [6:0]      hex_left_q, hex_left_d;
    logic [6:0]      hex_right_q, hex_right_d;

    logic            win_l_s, win_r_s;
    logic [3:0]      inc_l_s, inc_r_s;
    logic            blank_l_s, blank_r_s;

    // Both end lights lit is an illegal playfield state, so it never scores.
    assign win_l_s = lmost & ~rmost & L & ~R;
    assign win_r_s = rmost & ~lmost & R & ~L;
    assign inc_l_s = score_l_q + 4'd1;
    assign inc_r_s = score_r_q + 4'd1;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: wins only count in PLAY; HOLD times out; OVER is sticky.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAY: begin
                if (win_l_s) begin
                    state_d = (inc_l_s == LIMIT) ? OVER : HOLD;
                end else if (win_r_s) begin
                    state_d = (inc_r_s == LIMIT) ? OVER : HOLD;
                end else begin
                    state_d = PLAY;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = PLAY;
                end else begin
                    state_d = HOLD;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = PLAY;
        endcase
    end

    // Output/datapath logic: scores, hold counter, restart pulse, game_over.
    always_comb begin
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        hold_cnt_d    = '0;
        round_reset_d = 1'b0;
        case (state_q)
            PLAY: begin
                if (win_l_s) begin
                    score_l_d = inc_l_s;
                end else if (win_r_s) begin
                    score_r_d = inc_r_s;
                end else begin
                    score_l_d = score_l_q;
                end
            end
            HOLD: begin
                // The counter returns to zero only through the exit to PLAY.
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d    = '0;
                    round_reset_d = 1'b1;
                end else begin
                    hold_cnt_d    = hold_cnt_q + {{(HC_W-1){1'b0}}, 1'b1};
                end
            end
            OVER:    hold_cnt_d = '0;
            default: hold_cnt_d = '0;
        endcase
        game_over_d = (state_d == OVER);
    end

`ifdef SCORER_BLINK_EN
    localparam int              BC_W       = $clog2(BLINK_CYCLES + 1);
    localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_CYCLES - 1);

    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_off_q, blink_off_d;

    // Blink registers; cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    // Blink timing: restarts in the "shown" phase on OVER entry, then toggles
    // every BLINK_CYCLES cycles while the match stays over.
    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (state_q == OVER) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + {{(BC_W-1){1'b0}}, 1'b1};
                blink_off_d = blink_off_q;
            end
        end else begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end
    end

    // Only the digit that reached the limit blinks.
    assign blank_l_s = blink_off_d & (score_l_d == LIMIT);
    assign blank_r_s = blink_off_d & (score_r_d == LIMIT);
`else
    assign blank_l_s = 1'b0;
    assign blank_r_s = 1'b0;
`endif

    // Decode from the next-state scores so the registered display changes on
    // the same edge as the score itself.
    tow_seg7_digit u_digit_left (
        .value (score_l_d),
        .blank (blank_l_s),
        .seg   (hex_left_d)
    );

    tow_seg7_digit u_digit_right (
        .value (score_r_d),
        .blank (blank_r_s),
        .seg   (hex_right_d)
    );

    // Datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            hold_cnt_q    <= '0;
            round_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
            hex_left_q    <= SEG_DIGIT[0];
            hex_right_q   <= SEG_DIGIT[0];
        end else begin
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            hold_cnt_q    <= hold_cnt_d;
            round_reset_q <= round_reset_d;
            game_over_q   <= game_over_d;
            hex_left_q    <= hex_left_d;
            hex_right_q   <= hex_right_d;
        end
    end

    assign round_reset = round_reset_q;
    assign game_over   = game_over_q;
    assign hex_left    = hex_left_q;
    assign hex_right   = hex_right_q;

endmodule
